// File: rtl/tc_register_file_if.sv
// Bus bundle for tc_register_file: write port, read ports, clear request,
// registered read data and busy flag.
interface tc_register_file_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int NREAD = 2
);
  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  logic                   save;
  logic [AW-1:0]          waddr;
  logic [WIDTH-1:0]       in;
  logic [NREAD-1:0]       load;
  logic [NREAD*AW-1:0]    raddr;
  logic                   clear;
  logic [NREAD*WIDTH-1:0] out;
  logic                   busy;

  modport master (
    output save, waddr, in, load, raddr, clear,
    input  out, busy
  );

  modport slave (
    input  save, waddr, in, load, raddr, clear,
    output out, busy
  );
endinterface

// File: rtl/tc_register_file.sv
// Multi-port register file: one write port, NREAD registered read ports with
// write-through bypass, and a one-word-per-cycle clear sweep.
module tc_register_file #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int NREAD = 2
) (
  input  logic clk,
  input  logic rst,
  tc_register_file_if.slave bus
);
  localparam int              AW      = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]     DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]   LAST    = AW'(DEPTH - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t                 state, state_n;
  logic [AW-1:0]          ptr, ptr_n;
  logic [WIDTH-1:0]       mem [DEPTH];
  logic [NREAD*WIDTH-1:0] out_q, rd_n;
  logic                   busy;
  logic                   wr_ok;

  assign busy  = (state == SWEEP);
  assign wr_ok = bus.save && !busy && ({1'b0, bus.waddr} < DEPTH_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    case (state)
      IDLE: begin
        if (bus.clear) begin
          state_n = SWEEP;
          ptr_n   = '0;
        end
      end
      SWEEP: begin
        // Pointer stops at DEPTH-1, so it never addresses past the array.
        if (ptr == LAST) begin
          state_n = IDLE;
          ptr_n   = '0;
        end else begin
          ptr_n = ptr + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        ptr_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '{default: '0};
    end else if (busy) begin
      mem[ptr] <= '0;
    end else if (wr_ok) begin
      mem[bus.waddr] <= bus.in;
    end
  end

  // Disabled, out-of-range or busy reads return zero; a same-cycle write wins.
  always_comb begin
    logic [AW-1:0] ra;
    rd_n = '0;
    ra   = '0;
    for (int unsigned i = 0; i < NREAD; i++) begin
      ra = bus.raddr[i*AW +: AW];
      if (bus.load[i] && !busy && ({1'b0, ra} < DEPTH_W)) begin
        rd_n[i*WIDTH +: WIDTH] = (wr_ok && (bus.waddr == ra)) ? bus.in : mem[ra];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= rd_n;
    end
  end

  assign bus.out  = out_q;
  assign bus.busy = busy;
endmodule

// File: tb/tb_tc_register_file.sv
// Bench for tc_register_file: a DEPTH=16 and a DEPTH=12 instance driven by
// the same stimulus and checked against an array model of each.
module tb_tc_register_file;
  logic       clk = 1'b0;
  logic       rst;
  logic       save, clear;
  logic [3:0] waddr;
  logic [7:0] din;
  logic [1:0] load;
  logic [7:0] raddr;

  int tests = 0;
  int fails = 0;

  logic [7:0] mdl [2][16];
  int         sweep_left [2];
  logic [7:0] exp_out [2][2];

  tc_register_file_if #(.WIDTH(8), .DEPTH(16), .NREAD(2)) bus0 ();
  tc_register_file_if #(.WIDTH(8), .DEPTH(12), .NREAD(2)) bus1 ();

  assign bus0.save = save;   assign bus1.save = save;
  assign bus0.waddr = waddr; assign bus1.waddr = waddr;
  assign bus0.in = din;      assign bus1.in = din;
  assign bus0.load = load;   assign bus1.load = load;
  assign bus0.raddr = raddr; assign bus1.raddr = raddr;
  assign bus0.clear = clear; assign bus1.clear = clear;

  tc_register_file #(.WIDTH(8), .DEPTH(16), .NREAD(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  tc_register_file #(.WIDTH(8), .DEPTH(12), .NREAD(2)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  function automatic int depth(input int k);
    return (k == 0) ? 16 : 12;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    save = 1'b0; clear = 1'b0; waddr = '0; din = '0; load = '0; raddr = '0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      sweep_left[k] = 0;
      for (int a = 0; a < 16; a++) mdl[k][a] = '0;
      for (int i = 0; i < 2; i++) exp_out[k][i] = '0;
    end
  endtask

  // One clock edge of the reference behaviour for instance k.
  task automatic model_step(input int k);
    int  d;
    int  ra;
    bit  bsy;
    d   = depth(k);
    bsy = sweep_left[k] > 0;
    for (int i = 0; i < 2; i++) begin
      ra = int'(raddr[i*4 +: 4]);
      if (load[i] && !bsy && ra < d)
        exp_out[k][i] = (save && int'(waddr) == ra) ? din : mdl[k][ra];
      else
        exp_out[k][i] = '0;
    end
    if (bsy) begin
      mdl[k][d - sweep_left[k]] = '0;
      sweep_left[k]--;
    end else begin
      if (save && int'(waddr) < d) mdl[k][waddr] = din;
      if (clear) sweep_left[k] = d;
    end
  endtask

  task automatic check_all();
    logic [15:0] o;
    logic        b;
    for (int k = 0; k < 2; k++) begin
      o = (k == 0) ? bus0.out : bus1.out;
      b = (k == 0) ? bus0.busy : bus1.busy;
      chk($sformatf("busy_d%0d", depth(k)), 64'(b), 64'(sweep_left[k] > 0));
      for (int i = 0; i < 2; i++)
        chk($sformatf("out_d%0d_p%0d", depth(k), i), 64'(o[i*8 +: 8]), 64'(exp_out[k][i]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      model_step(0);
      model_step(1);
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic fill();
    for (int a = 0; a < 16; a++) begin
      save = 1'b1; waddr = 4'(a); din = 8'h80 | 8'(a * 3 + 1);
      tick();
    end
    idle();
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 40; n++) begin
      if (!bus0.busy && !bus1.busy) break;
      tick();
    end
    chk("idle_timeout", 64'(bus0.busy | bus1.busy), 64'd0);
  endtask

  initial begin
    int cnt;
    idle();
    rst = 1'b1;
    model_reset();
    #2;
    check_all();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Basic write then read
    save = 1'b1; waddr = 4'd3; din = 8'hA5;
    tick();
    idle(); load = 2'b01; raddr = {4'd0, 4'd3};
    tick();
    chk("r035_out0", 64'(bus0.out[7:0]), 64'hA5);
    chk("r035_out1", 64'(bus0.out[15:8]), 64'h00);

    // Read-during-write bypass
    idle(); save = 1'b1; waddr = 4'd5; din = 8'h11;
    tick();
    save = 1'b1; waddr = 4'd5; din = 8'h3C; load = 2'b10; raddr = {4'd5, 4'd0};
    tick();
    chk("r036_bypass", 64'(bus0.out[15:8]), 64'h3C);
    idle();

    // Clear sweep: busy length, save ignored, everything zero afterwards
    fill();
    clear = 1'b1;
    tick();
    idle();
    cnt = 0;
    for (int n = 0; n < 40; n++) begin
      if (!bus0.busy) break;
      cnt++;
      save = 1'b1; waddr = 4'($urandom); din = 8'($urandom) | 8'h01;
      tick();
    end
    idle();
    chk("r037_busy_cycles", 64'(cnt), 64'd16);
    wait_idle();
    for (int a = 0; a < 16; a++) begin
      load = 2'b11; raddr = {4'(a), 4'(a)};
      tick();
      chk("r037_zero", 64'(bus0.out), 64'h0000);
    end
    idle();

    // Boundary on the DEPTH=12 instance
    save = 1'b1; waddr = 4'd11; din = 8'h5A;
    tick();
    save = 1'b1; waddr = 4'd13; din = 8'h77;
    tick();
    idle(); load = 2'b11; raddr = {4'd13, 4'd11};
    tick();
    chk("r038_addr11", 64'(bus1.out[7:0]), 64'h5A);
    chk("r038_addr13", 64'(bus1.out[15:8]), 64'h00);
    idle();

    // Reset in the middle of a sweep
    fill();
    clear = 1'b1;
    tick();
    idle();
    tick(); tick(); tick();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("r039_busy", 64'(bus0.busy), 64'd0);
    chk("r039_out", 64'(bus0.out), 64'h0000);
    check_all();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    save = 1'b1; waddr = 4'd0; din = 8'h7E;
    tick();
    idle(); load = 2'b01; raddr = 8'h00;
    tick();
    chk("r039_after", 64'(bus0.out[7:0]), 64'h7E);
    for (int a = 1; a < 16; a++) begin
      load = 2'b11; raddr = {4'(a), 4'(a)};
      tick();
      chk("r039_zero", 64'(bus0.out), 64'h0000);
    end
    idle();

    // Clear and save in the same idle cycle
    save = 1'b1; clear = 1'b1; waddr = 4'd2; din = 8'hFF;
    tick();
    idle();
    wait_idle();
    load = 2'b01; raddr = 8'h02;
    tick();
    chk("r040_addr2", 64'(bus0.out[7:0]), 64'h00);
    idle();

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      save  = 1'($urandom);
      waddr = 4'($urandom);
      din   = 8'($urandom);
      load  = 2'($urandom);
      raddr = (($urandom % 4) == 0) ? {waddr, waddr} : 8'($urandom);
      clear = (($urandom % 30) == 0);
      tick();
    end
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
